// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the PC fetch sequencer: state encodings and default parameters.
package pc_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_HALTED = 2'b11
    } state_t;

    localparam int unsigned PC_WIDTH             = 16;
    localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'h0000;
    localparam int unsigned DEFAULT_WAIT_LIMIT   = 15;

endpackage

// File: rtl/pc_fetch_sequencer_incr.sv
// Combinational PC+1 built as a ripple chain of half-adders; carry_out flags wrap-around.
module pc_incr
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH
) (
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] pc_out,
    output logic             carry_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ha
        assign pc_out[i]    = pc_in[i] ^ carry[i];
        assign carry[i+1]   = pc_in[i] & carry[i];
    end

    assign carry_out = carry[WIDTH];

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter and instruction-fetch sequencer over a REQ/ACK memory handshake.
//   state     | meaning
//   ST_IDLE   | no request outstanding; waits for EN=1 and STALL=0
//   ST_REQ    | MEM_REQ high at PC until MEM_ACK, timeout or HALT
//   ST_HALTED | stopped; leaves only on REDIRECT
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int unsigned      WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned      WAIT_LIMIT   = DEFAULT_WAIT_LIMIT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             STALL,
    input  logic             REDIRECT,
    input  logic [WIDTH-1:0] TARGET,
    input  logic             HALT,
    output logic             MEM_REQ,
    output logic [WIDTH-1:0] MEM_ADDR,
    input  logic             MEM_ACK,
    output logic             INSTR_VALID,
    output logic [WIDTH-1:0] INSTR_ADDR,
    output logic [WIDTH-1:0] PC,
    output logic             WRAP,
    output logic             TIMEOUT,
    output logic [1:0]       STATE
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic [7:0]       wait_q, wait_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] iaddr_q, iaddr_d;
    logic             wrap_q, wrap_d;
    logic             timeout_q, timeout_d;

    logic [WIDTH-1:0] pc_inc;
    logic             pc_carry;

    pc_incr #(.WIDTH(WIDTH)) u_incr (
        .pc_in     (pc_q),
        .pc_out    (pc_inc),
        .carry_out (pc_carry)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_VECTOR;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            wait_q     <= '0;
            valid_q    <= 1'b0;
            iaddr_q    <= '0;
            wrap_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            wait_q     <= wait_d;
            valid_q    <= valid_d;
            iaddr_q    <= iaddr_d;
            wrap_q     <= wrap_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        wait_d     = wait_q;
        valid_d    = 1'b0;
        iaddr_d    = iaddr_q;
        wrap_d     = wrap_q;
        timeout_d  = timeout_q;

        if (HALT) begin
            state_d = ST_HALTED;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (REDIRECT) pc_d = TARGET;
                    if (EN && !STALL) state_d = ST_REQ;
                end
                ST_REQ: begin
                    if (!MEM_ACK) begin
                        wait_d = wait_q + 8'd1;
                        if (wait_q == WAIT_LAST) begin
                            timeout_d = 1'b1;
                            state_d   = ST_HALTED;
                            pend_d    = 1'b0;
                        end else if (REDIRECT) begin
                            pend_d     = 1'b1;
                            pend_tgt_d = TARGET;
                        end
                    end else begin
                        wait_d = '0;
                        // A redirect seen during this fetch means the returned word is stale.
                        if (REDIRECT || pend_q) begin
                            pc_d   = REDIRECT ? TARGET : pend_tgt_q;
                            pend_d = 1'b0;
                        end else begin
                            valid_d = 1'b1;
                            iaddr_d = pc_q;
                            pc_d    = pc_inc;
                            wrap_d  = wrap_q | pc_carry;
                        end
                        state_d = (EN && !STALL) ? ST_REQ : ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    if (REDIRECT) begin
                        pc_d    = TARGET;
                        state_d = ST_IDLE;
                        wait_d  = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign MEM_REQ     = (state_q == ST_REQ);
    assign MEM_ADDR    = pc_q;
    assign PC          = pc_q;
    assign INSTR_VALID = valid_q;
    assign INSTR_ADDR  = iaddr_q;
    assign WRAP        = wrap_q;
    assign TIMEOUT     = timeout_q;
    assign STATE       = state_q;

endmodule
